// File: rtl/sprite_compositor.sv
// Sprite layer: hit test and sprite RAM addressing, a RAM_LAT delay line aligned with the returned
// data, priority compose over the background and sticky player collision. Define TRANSPARENT_KEY_EN for colour-key transparency.
module sprite_compositor #(
    parameter int          NUM_SPRITES = 4,
    parameter int          SPR_SIZE    = 26,
    parameter int          ADDR_W      = 13,
    parameter int          RAM_LAT     = 1,
    parameter int          ACTIVE_W    = 405,
    parameter int          ANIM_DIV    = 8,
    parameter logic [23:0] KEY_COLOR   = 24'h000000
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic [9:0]                    DrawX,
    input  logic [9:0]                    DrawY,
    input  logic                          blank,
    input  logic                          frame_start,
    input  logic [23:0]                   bg_rgb,
    input  logic [NUM_SPRITES-1:0]        spr_en,
    input  logic [10*NUM_SPRITES-1:0]     spr_x,
    input  logic [10*NUM_SPRITES-1:0]     spr_y,
    input  logic [2*NUM_SPRITES-1:0]      spr_dir,
    output logic [ADDR_W*NUM_SPRITES-1:0] spr_addr,
    input  logic [24*NUM_SPRITES-1:0]     spr_data,
    output logic [7:0]                    Red,
    output logic [7:0]                    Green,
    output logic [7:0]                    Blue,
    output logic                          collision,
    output logic                          anim_phase
);

`ifdef TRANSPARENT_KEY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    localparam int                CNT_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic signed [11:0] HALF_S   = 12'(SPR_SIZE / 2);
    localparam logic signed [11:0] SIDE_MAX = 12'(SPR_SIZE - 1);

    typedef struct packed {
        logic [NUM_SPRITES-1:0] hit;
        logic                   blank;
        logic                   off;
        logic [23:0]            bg;
    } pix_t;

    pix_t                          r_s1;
    pix_t                          r_dly [RAM_LAT];
    logic [ADDR_W*NUM_SPRITES-1:0] r_addr;
    logic [23:0]                   r_rgb;
    logic                          r_collision;
    logic [CNT_W-1:0]              r_cnt;
    logic                          r_phase;

    logic [NUM_SPRITES-1:0]        w_hit;
    logic [ADDR_W*NUM_SPRITES-1:0] w_addr;
    logic signed [11:0]            w_dx [NUM_SPRITES];
    logic signed [11:0]            w_dy [NUM_SPRITES];
    logic [2:0]                    w_frame [NUM_SPRITES];
    pix_t                          w_tap;
    logic [NUM_SPRITES-1:0]        w_opaque;
    logic                          w_others;
    logic [23:0]                   w_pix;

    // Offsets are 12-bit signed so sprites hanging off the left/top edge clip cleanly.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves a bit unassigned (no latch).
        w_hit  = '0;
        w_addr = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            w_dx[i]    = $signed({2'b00, DrawX}) - ($signed({2'b00, spr_x[10*i +: 10]}) - HALF_S);
            w_dy[i]    = $signed({2'b00, DrawY}) - ($signed({2'b00, spr_y[10*i +: 10]}) - HALF_S);
            w_frame[i] = {spr_dir[2*i +: 2], r_phase};
            w_hit[i]   = spr_en[i] && (w_dx[i] >= 12'sd0) && (w_dx[i] <= SIDE_MAX)
                                   && (w_dy[i] >= 12'sd0) && (w_dy[i] <= SIDE_MAX);
            if (w_hit[i]) begin
                w_addr[ADDR_W*i +: ADDR_W] = ADDR_W'(w_dy[i]) * ADDR_W'(SPR_SIZE) + ADDR_W'(w_dx[i])
                                           + ADDR_W'(w_frame[i]) * ADDR_W'(SPR_SIZE * SPR_SIZE);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s1   <= '0;
            r_addr <= '0;
            // NOTE: the delay line is reset too, so stale hits cannot leak out while the pipe refills.
            for (int k = 0; k < RAM_LAT; k++) r_dly[k] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
            r_s1   <= '{hit: w_hit, blank: blank, off: (DrawX >= 10'(ACTIVE_W)), bg: bg_rgb};
            r_addr <= w_addr;
            r_dly[0] <= r_s1;
            for (int k = 1; k < RAM_LAT; k++) r_dly[k] <= r_dly[k-1];
        end
    end

    assign w_tap = r_dly[RAM_LAT-1];

    // Lowest channel wins: walk from the highest index down so channel 0 overwrites last.
    always_comb begin
        w_opaque = '0;
        w_others = 1'b0;
        w_pix    = w_tap.bg;
        for (int i = 0; i < NUM_SPRITES; i++)
            w_opaque[i] = w_tap.hit[i] && (!KEY_EN || (spr_data[24*i +: 24] != KEY_COLOR));
        for (int i = NUM_SPRITES - 1; i >= 0; i--)
            if (w_opaque[i]) w_pix = spr_data[24*i +: 24];
        for (int i = 1; i < NUM_SPRITES; i++)
            w_others = w_others | w_opaque[i];
        if (!w_tap.blank || w_tap.off) w_pix = '0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rgb       <= '0;
            r_collision <= 1'b0;
            r_cnt       <= '0;
            r_phase     <= 1'b0;
        end else begin
            r_rgb <= w_pix;
            if (w_opaque[0] && w_others) r_collision <= 1'b1;
            else if (frame_start)        r_collision <= 1'b0;
            if (frame_start) begin
                if (r_cnt == CNT_W'(ANIM_DIV - 1)) begin
                    r_cnt   <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign spr_addr   = r_addr;
    assign Red        = r_rgb[23:16];
    assign Green      = r_rgb[15:8];
    assign Blue       = r_rgb[7:0];
    assign collision  = r_collision;
    assign anim_phase = r_phase;

endmodule

// File: tb/tb_sprite_compositor.sv
// Randomised bench for sprite_compositor: a per-pixel reference model computes hit, address,
// priority colour and collision from the geometric rules; results are compared at the pipeline outputs.
module tb_sprite_compositor;

    localparam int N        = 4;
    localparam int SZ       = 26;
    localparam int AW       = 13;
    localparam int ACTIVE_W = 405;
    localparam int ANIM_DIV = 8;

    logic            Clk;
    logic            Reset_n;
    logic [9:0]      DrawX;
    logic [9:0]      DrawY;
    logic            blank;
    logic            frame_start;
    logic [23:0]     bg_rgb;
    logic [N-1:0]    spr_en;
    logic [10*N-1:0] spr_x;
    logic [10*N-1:0] spr_y;
    logic [2*N-1:0]  spr_dir;
    logic [AW*N-1:0] spr_addr;
    logic [24*N-1:0] spr_data;
    logic [7:0]      Red;
    logic [7:0]      Green;
    logic [7:0]      Blue;
    logic            collision;
    logic            anim_phase;

    int          n_checks;
    int          n_fail;
    int          sx   [N];
    int          sy   [N];
    int          sdir [N];
    bit          sen  [N];
    int          m_phase;
    int          m_cnt;
    bit          m_col;
    logic [23:0] q_rgb [$];
    bit          q_ov  [$];

    sprite_compositor dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .blank      (blank),
        .frame_start(frame_start),
        .bg_rgb     (bg_rgb),
        .spr_en     (spr_en),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .spr_dir    (spr_dir),
        .spr_addr   (spr_addr),
        .spr_data   (spr_data),
        .Red        (Red),
        .Green      (Green),
        .Blue       (Blue),
        .collision  (collision),
        .anim_phase (anim_phase)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Sprite RAM contents; every ninth word is black to exercise black-but-opaque pixels.
    function automatic logic [23:0] ram_word(input int ch, input int addr);
        if (addr % 9 == 0) return 24'h000000;
        return 24'(addr * 40503 + ch * 5368071 + 1193046);
    endfunction

    // Single-cycle-latency sprite RAMs.
    always @(posedge Clk) begin
        for (int i = 0; i < N; i++)
            spr_data[24*i +: 24] <= ram_word(i, int'(spr_addr[AW*i +: AW]));
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_phase = 0;
        m_cnt   = 0;
        m_col   = 1'b0;
        q_rgb   = {24'h0, 24'h0};
        q_ov    = {1'b0, 1'b0};
    endtask

    task automatic set_sprite(input int i, input bit en, input int x, input int y, input int dir);
        sen[i]  = en;
        sx[i]   = x;
        sy[i]   = y;
        sdir[i] = dir;
    endtask

    task automatic disable_all();
        for (int i = 0; i < N; i++) set_sprite(i, 1'b0, 0, 0, 0);
    endtask

    // Drive one pixel at a falling edge, predict its results, then check one cycle later.
    task automatic step(input int x, input int y, input bit bl, input bit fs);
        logic [AW*N-1:0] exp_addr;
        logic [23:0]     bg;
        logic [23:0]     pix;
        logic [23:0]     exp_rgb;
        int              win;
        int              dx;
        int              dy;
        int              a;
        bit              hit0;
        bit              hit_other;
        bit              ov_now;
        bg          = 24'($urandom);
        DrawX       = 10'(x);
        DrawY       = 10'(y);
        blank       = bl;
        frame_start = fs;
        bg_rgb      = bg;
        for (int i = 0; i < N; i++) begin
            spr_en[i]             = sen[i];
            spr_x[10*i +: 10]     = 10'(sx[i]);
            spr_y[10*i +: 10]     = 10'(sy[i]);
            spr_dir[2*i +: 2]     = 2'(sdir[i]);
        end
        exp_addr  = '0;
        win       = -1;
        hit0      = 1'b0;
        hit_other = 1'b0;
        pix       = bg;
        for (int i = 0; i < N; i++) begin
            dx = x - (sx[i] - SZ / 2);
            dy = y - (sy[i] - SZ / 2);
            if (sen[i] && dx >= 0 && dx < SZ && dy >= 0 && dy < SZ) begin
                a = (dy * SZ + dx + (2 * sdir[i] + m_phase) * SZ * SZ) % (1 << AW);
                exp_addr[AW*i +: AW] = AW'(a);
                if (win < 0) begin
                    win = i;
                    pix = ram_word(i, a);
                end
                if (i == 0) hit0 = 1'b1;
                else        hit_other = 1'b1;
            end
        end
        if (!bl || x >= ACTIVE_W) pix = 24'h0;
        q_rgb.push_back(pix);
        q_ov.push_back(hit0 && hit_other);
        if (fs) begin
            if (m_cnt == ANIM_DIV - 1) begin
                m_cnt   = 0;
                m_phase = 1 - m_phase;
            end else begin
                m_cnt++;
            end
        end
        @(posedge Clk);
        @(negedge Clk);
        exp_rgb = q_rgb.pop_front();
        ov_now  = q_ov.pop_front();
        if (ov_now)  m_col = 1'b1;
        else if (fs) m_col = 1'b0;
        check("spr_addr", 64'(spr_addr), 64'(exp_addr));
        check("rgb", 64'({Red, Green, Blue}), 64'(exp_rgb));
        check("collision", 64'(collision), 64'(m_col));
        check("anim_phase", 64'(anim_phase), 64'(m_phase));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb"}, 64'({Red, Green, Blue}), 64'h0);
        check({tag, "_collision"}, 64'(collision), 64'h0);
        check({tag, "_phase"}, 64'(anim_phase), 64'h0);
        check({tag, "_addr"}, 64'(spr_addr), 64'h0);
    endtask

    initial begin
        int k;
        int px;
        int py;
        n_checks    = 0;
        n_fail      = 0;
        Reset_n     = 1'b1;
        DrawX       = '0;
        DrawY       = '0;
        blank       = 1'b0;
        frame_start = 1'b0;
        bg_rgb      = '0;
        spr_en      = '0;
        spr_x       = '0;
        spr_y       = '0;
        spr_dir     = '0;
        disable_all();
        #2 Reset_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(negedge Clk);
        check_reset_outputs("reset_held");
        Reset_n = 1'b1;
        reset_model();

        // Single sprite: corners, just outside, centre.
        set_sprite(0, 1'b1, 100, 100, 0);
        step(87, 87, 1'b1, 1'b0);
        step(113, 113, 1'b1, 1'b0);
        step(114, 100, 1'b1, 1'b0);
        step(100, 100, 1'b1, 1'b0);
        step(88, 87, 1'b1, 1'b0);
        repeat (3) step(300, 300, 1'b1, 1'b0);

        // Direction frames and animation phase over sixteen frame pulses.
        sdir[0] = 3;
        repeat (8) step(300, 300, 1'b1, 1'b1);
        step(87, 87, 1'b1, 1'b0);
        repeat (3) step(300, 300, 1'b1, 1'b0);
        repeat (7) step(300, 300, 1'b1, 1'b1);
        step(87, 87, 1'b1, 1'b0);
        step(300, 300, 1'b1, 1'b1);
        step(87, 87, 1'b1, 1'b0);
        repeat (3) step(300, 300, 1'b1, 1'b0);

        // Overlap priority, sticky collision, set-beats-clear.
        disable_all();
        set_sprite(0, 1'b1, 50, 50, 0);
        set_sprite(1, 1'b1, 50, 50, 1);
        repeat (3) step(50, 50, 1'b1, 1'b0);
        repeat (3) step(200, 200, 1'b1, 1'b0);
        step(50, 50, 1'b1, 1'b0);
        step(200, 200, 1'b1, 1'b0);
        step(200, 200, 1'b1, 1'b1);
        step(200, 200, 1'b1, 1'b1);
        repeat (2) step(200, 200, 1'b1, 1'b0);

        // Playfield edge, blanking and left-edge clipping.
        disable_all();
        set_sprite(0, 1'b1, 405, 100, 0);
        step(405, 100, 1'b1, 1'b0);
        step(404, 100, 1'b1, 1'b0);
        step(400, 100, 1'b0, 1'b0);
        set_sprite(0, 1'b1, 5, 50, 2);
        step(0, 50, 1'b1, 1'b0);
        step(0, 37, 1'b1, 1'b0);
        repeat (3) step(300, 300, 1'b1, 1'b0);

        // Build up phase 1 and a set collision, then reset mid-line.
        disable_all();
        set_sprite(0, 1'b1, 60, 60, 1);
        set_sprite(1, 1'b1, 62, 58, 2);
        repeat (8) step(0, 0, 1'b1, 1'b1);
        step(60, 60, 1'b1, 1'b0);
        repeat (3) step(61, 60, 1'b1, 1'b0);
        Reset_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        reset_model();
        repeat (4) step(60, 60, 1'b1, 1'b0);

        // Randomised scenes.
        for (int scene = 0; scene < 40; scene++) begin
            for (int i = 0; i < N; i++) begin
                set_sprite(i, $urandom_range(0, 3) != 0, $urandom_range(0, 140),
                           $urandom_range(0, 140), $urandom_range(0, 3));
            end
            if (scene % 4 == 1) sx[3] = $urandom_range(390, 420);
            for (int p = 0; p < 50; p++) begin
                if ($urandom_range(0, 9) < 7) begin
                    k  = $urandom_range(0, N - 1);
                    px = sx[k] + $urandom_range(0, 30) - 15;
                    py = sy[k] + $urandom_range(0, 30) - 15;
                end else begin
                    px = $urandom_range(0, 430);
                    py = $urandom_range(0, 160);
                end
                if (px < 0) px = 0;
                if (py < 0) py = 0;
                step(px, py, $urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0);
            end
        end
        repeat (3) step(300, 300, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
